// File: rtl/common.sv
// Shared raster GPU definitions used by the CPU, the command queue and the GPU.
package common;

    typedef enum logic [2:0] {
        NOP   = 3'd0,
        POINT = 3'd1,
        LINE  = 3'd2,
        RECT  = 3'd3,
        FILL  = 3'd4
    } raster_command_t;

endpackage

// File: rtl/gpu_cmd_queue.sv
// Command FIFO between the CPU and the raster GPU; issues one queued command at a time
// with a single-cycle gpu_execute_request pulse, never while the GPU is busy.
module gpu_cmd_queue
    import common::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_async,
    input  raster_command_t          in_command,
    input  logic [7:0]               in_x0,
    input  logic [7:0]               in_y0,
    input  logic [7:0]               in_x1,
    input  logic [7:0]               in_y1,
    input  logic [2:0]               in_colour,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     flush,
    output raster_command_t          gpu_command,
    output logic [7:0]               gpu_x0,
    output logic [7:0]               gpu_y0,
    output logic [7:0]               gpu_x1,
    output logic [7:0]               gpu_y1,
    output logic [2:0]               gpu_colour,
    output logic                     gpu_execute_request,
    input  logic                     gpu_busy,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     all_idle,
    output logic [1:0]               dbg_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        raster_command_t cmd;
        logic [7:0]      x0;
        logic [7:0]      y0;
        logic [7:0]      x1;
        logic [7:0]      y1;
        logic [2:0]      colour;
    } entry_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_SETTLE = 2'd2,
        S_WAIT   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    entry_t          mem_q [DEPTH];
    entry_t          out_q, out_d;
    entry_t          in_entry;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            push;
    logic            pop;

    // Input handshake: a command transfers on an edge where in_valid and in_ready are
    // both high; in_ready depends only on registered occupancy, never on a same-cycle pop.
    assign in_ready = (count_q != CW'(DEPTH));
    assign push     = in_valid && in_ready && !flush;

    assign in_entry = '{cmd: in_command, x0: in_x0, y0: in_y0, x1: in_x1, y1: in_y1,
                        colour: in_colour};

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        out_d    = out_q;
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
                out_d    = mem_q[rd_ptr_q];
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_entry;
    end

    always_ff @(posedge clk or negedge rst_async) begin
        if (!rst_async) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            out_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            out_q    <= out_d;
        end
    end

    always_ff @(posedge clk or negedge rst_async) begin
        if (!rst_async) state_q <= S_IDLE;
        else            state_q <= state_d;
    end

    // SETTLE ignores gpu_busy: the GPU only raises it the cycle after the request.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (pop) state_d = S_ISSUE;
            S_ISSUE:  state_d = S_SETTLE;
            S_SETTLE: state_d = S_WAIT;
            S_WAIT:   if (!gpu_busy) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pop                 = 1'b0;
        gpu_execute_request = 1'b0;
        case (state_q)
            S_IDLE:  pop = (count_q != '0) && !gpu_busy && !flush;
            S_ISSUE: gpu_execute_request = 1'b1;
            default: ;
        endcase
    end

    assign all_idle    = (count_q == '0) && (state_q == S_IDLE) && !gpu_busy;
    assign fifo_count  = count_q;
    assign dbg_state   = state_q;
    assign gpu_command = out_q.cmd;
    assign gpu_x0      = out_q.x0;
    assign gpu_y0      = out_q.y0;
    assign gpu_x1      = out_q.x1;
    assign gpu_y1      = out_q.y1;
    assign gpu_colour  = out_q.colour;

endmodule

// File: tb/tb_gpu_cmd_queue.sv
// Randomised bench for gpu_cmd_queue: a queue-based reference model, a GPU busy model,
// and a per-cycle compare process, plus directed scenarios with literal expectations.
module tb_gpu_cmd_queue;
    import common::*;

    localparam int DEPTH = 8;
    localparam int EW    = 38;
    typedef logic [EW-1:0] entry_t;

    logic            clk = 1'b0;
    logic            rst_async = 1'b1;
    raster_command_t in_command = NOP;
    logic [7:0]      in_x0 = '0, in_y0 = '0, in_x1 = '0, in_y1 = '0;
    logic [2:0]      in_colour = '0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic            flush = 1'b0;
    raster_command_t gpu_command;
    logic [7:0]      gpu_x0, gpu_y0, gpu_x1, gpu_y1;
    logic [2:0]      gpu_colour;
    logic            gpu_execute_request;
    logic            gpu_busy;
    logic [3:0]      fifo_count;
    logic            all_idle;
    logic [1:0]      dbg_state;

    logic ext_busy = 1'b0;
    logic gpu_busy_int = 1'b0;
    assign gpu_busy = ext_busy | gpu_busy_int;

    gpu_cmd_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_async(rst_async),
        .in_command(in_command), .in_x0(in_x0), .in_y0(in_y0), .in_x1(in_x1), .in_y1(in_y1),
        .in_colour(in_colour), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .gpu_command(gpu_command), .gpu_x0(gpu_x0), .gpu_y0(gpu_y0), .gpu_x1(gpu_x1),
        .gpu_y1(gpu_y1), .gpu_colour(gpu_colour), .gpu_execute_request(gpu_execute_request),
        .gpu_busy(gpu_busy), .fifo_count(fifo_count), .all_idle(all_idle),
        .dbg_state(dbg_state)
    );

    // 50 MHz
    always #10 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int n_req = 0;
    int cyc = 0;
    int last_req = -100;

    entry_t exp_q[$];
    entry_t m_out;
    bit     m_released;
    int     m_after;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int op_len(input raster_command_t c);
        case (c)
            POINT:   return 1;
            LINE:    return 3;
            RECT:    return 5;
            FILL:    return 50;
            default: return 1;
        endcase
    endfunction

    function automatic raster_command_t rand_cmd();
        int r;
        r = $urandom_range(0, 9);
        if (r < 6)      return POINT;
        else if (r < 7) return FILL;
        else if (r < 8) return LINE;
        else if (r < 9) return RECT;
        else            return NOP;
    endfunction

    function automatic entry_t cur_in();
        return {in_command, in_x0, in_y0, in_x1, in_y1, in_colour};
    endfunction

    task automatic m_reset();
        exp_q.delete();
        m_out      = '0;
        m_released = 1'b1;
        m_after    = 100;
    endtask

    // Reference model: a plain queue, plus "cycles since the last issue" to decide when
    // the issuer may send again (two fixed cycles, then the first edge seeing busy low).
    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge rst_async);
            if (!rst_async) begin
                m_reset();
            end else begin
                bit b, do_pop, do_push;
                int sz;
                b       = gpu_busy;
                sz      = exp_q.size();
                do_pop  = m_released && sz != 0 && !b && !flush;
                do_push = in_valid && sz != DEPTH && !flush;
                if (flush) exp_q.delete();
                if (do_pop) m_out = exp_q.pop_front();
                if (do_push) exp_q.push_back(cur_in());
                if (do_pop) begin
                    m_after    = 0;
                    m_released = 1'b0;
                end else begin
                    if (!m_released && m_after >= 2 && !b) m_released = 1'b1;
                    if (m_after < 100) m_after++;
                end
            end
        end
    end

    // GPU model: samples the request, raises busy the following cycle for op_len cycles.
    initial begin
        int rem;
        int len;
        bit pend;
        rem = 0; len = 0; pend = 1'b0;
        forever begin
            @(negedge clk);
            if (gpu_execute_request) begin
                pend = 1'b1;
                len  = op_len(gpu_command);
            end
            @(posedge clk);
            #2;
            if (pend) begin
                rem  = len;
                pend = 1'b0;
            end else if (rem > 0) begin
                rem--;
            end
            gpu_busy_int = (rem > 0);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            chk("request", gpu_execute_request, rst_async && m_after == 0);
            chk("fifo_count", fifo_count, exp_q.size());
            chk("in_ready", in_ready, exp_q.size() != DEPTH);
            chk("all_idle", all_idle, m_released && exp_q.size() == 0 && !gpu_busy);
            chk("gpu_data", {gpu_command, gpu_x0, gpu_y0, gpu_x1, gpu_y1, gpu_colour}, m_out);
            if (gpu_execute_request) begin
                n_req++;
                chk("req_busy_low", gpu_busy, 1'b0);
                chk("req_spacing", (cyc - last_req) >= 4, 1'b1);
                last_req = cyc;
            end
        end
    end

    task automatic drive(input raster_command_t c, input logic [7:0] x0, input logic [7:0] y0,
                         input logic [7:0] x1, input logic [7:0] y1, input logic [2:0] col);
        in_command = c;
        in_x0 = x0; in_y0 = y0; in_x1 = x1; in_y1 = y1;
        in_colour = col;
    endtask

    task automatic drive_rand(input raster_command_t c);
        drive(c, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 3'($urandom));
    endtask

    task automatic push_cur();
        int t;
        t = 0;
        in_valid = 1'b1;
        while (!in_ready && t < 200) begin
            @(posedge clk); #3;
            t++;
        end
        if (!in_ready) chk("push_timeout", 0, 1);
        @(posedge clk); #3;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int t;
        t = 0;
        while (!(all_idle && exp_q.size() == 0 && !gpu_busy) && t < budget) begin
            @(posedge clk); #3;
            t++;
        end
        chk("idle_reached", all_idle, 1'b1);
    endtask

    task automatic wait_request(input int budget);
        int t;
        t = 0;
        while (!gpu_execute_request && t < budget) begin
            @(negedge clk);
            t++;
        end
        chk("request_seen", gpu_execute_request, 1'b1);
        @(posedge clk); #3;
    endtask

    initial begin
        #(20 * 60000);
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int snap, pairs;
        bit prev;

        #1 rst_async = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        chk("rst_count", fifo_count, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_req", gpu_execute_request, 0);
        chk("rst_idle", all_idle, 1);
        chk("rst_x0", gpu_x0, 0);
        @(posedge clk); #5 rst_async = 1'b1;
        @(posedge clk); #3;

        // Single RECT push: pop one edge later, one-cycle request two edges after push.
        wait_idle(50);
        drive(RECT, 8'd10, 8'd90, 8'd204, 8'd130, 3'b110);
        push_cur();
        @(negedge clk);
        chk("t1_count_after_push", fifo_count, 1);
        chk("t1_no_req_yet", gpu_execute_request, 0);
        @(negedge clk);
        chk("t1_req", gpu_execute_request, 1);
        chk("t1_cmd", gpu_command, RECT);
        chk("t1_x0", gpu_x0, 10);
        chk("t1_y1", gpu_y1, 130);
        chk("t1_colour", gpu_colour, 3'b110);
        chk("t1_count_zero", fifo_count, 0);
        @(negedge clk);
        chk("t1_req_dropped", gpu_execute_request, 0);
        @(posedge clk); #3;

        // Fill while busy, refuse a 9th offer, then drain in order.
        wait_idle(100);
        ext_busy = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            drive_rand(rand_cmd() == FILL ? LINE : POINT);
            push_cur();
        end
        chk("t2_full_count", fifo_count, 8);
        chk("t2_full_ready", in_ready, 0);
        drive_rand(POINT);
        in_valid = 1'b1;
        repeat (3) begin @(posedge clk); #3; end
        chk("t2_ninth_refused", fifo_count, 8);
        in_valid = 1'b0;
        snap = n_req;
        ext_busy = 1'b0;
        wait_idle(400);
        chk("t2_all_issued", n_req - snap, 8);

        // Random traffic with short and long GPU operations.
        for (int i = 0; i < 1500; i++) begin
            drive_rand(rand_cmd());
            in_valid = ($urandom_range(0, 2) == 0);
            flush    = ($urandom_range(0, 199) == 0);
            @(posedge clk); #3;
        end
        in_valid = 1'b0;
        flush    = 1'b0;
        wait_idle(3000);

        // Push exactly on the pop edges: occupancy stays at 3 and the pointers wrap.
        ext_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_rand(POINT);
            push_cur();
        end
        chk("t4_count3", fifo_count, 3);
        ext_busy = 1'b0;
        pairs = 0;
        prev  = 1'b0;
        for (int t = 0; t < 400 && pairs < 20; t++) begin
            @(negedge clk);
            if (prev) begin
                chk("t4_pair_count", fifo_count, 3);
                pairs++;
            end
            #1;
            prev = m_released && exp_q.size() != 0 && !gpu_busy && pairs < 20;
            drive_rand(POINT);
            in_valid = prev;
        end
        in_valid = 1'b0;
        chk("t4_pairs_done", pairs, 20);
        @(posedge clk); #3;
        wait_idle(200);

        // Flush during WAIT of a long operation; a push in the flush cycle is dropped.
        ext_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive_rand(FILL);
            push_cur();
        end
        ext_busy = 1'b0;
        wait_request(20);
        repeat (6) begin @(posedge clk); #3; end
        snap = n_req;
        flush = 1'b1;
        drive_rand(POINT);
        in_valid = 1'b1;
        @(posedge clk); #3;
        flush = 1'b0;
        in_valid = 1'b0;
        chk("t5_flushed_count", fifo_count, 0);
        wait_idle(200);
        chk("t5_no_more_requests", n_req - snap, 0);
        chk("t5_all_idle", all_idle, 1);

        // Asynchronous reset mid-operation, between clock edges.
        ext_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive_rand(FILL);
            push_cur();
        end
        ext_busy = 1'b0;
        wait_request(20);
        repeat (4) begin @(posedge clk); #3; end
        chk("t6_count4", fifo_count, 4);
        #2 rst_async = 1'b0;
        #1;
        chk("t6_rst_req", gpu_execute_request, 0);
        chk("t6_rst_count", fifo_count, 0);
        chk("t6_rst_ready", in_ready, 1);
        chk("t6_rst_data", {gpu_command, gpu_x0, gpu_y0, gpu_x1, gpu_y1, gpu_colour}, 0);
        chk("t6_rst_idle_busy", all_idle, 0);
        @(posedge clk); #5 rst_async = 1'b1;
        snap = n_req;
        repeat (80) begin @(posedge clk); #3; end
        chk("t6_no_req_after_reset", n_req - snap, 0);
        chk("t6_idle_after", all_idle, 1);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
